// File: rtl/axil_pkg.sv
// Shared AXI4-Lite definitions for the register file: widths,
// response codes and the byte-lane merge helper.
package axil_pkg;

   localparam int DATA_W = 32;
   localparam int STRB_W = DATA_W / 8;

   typedef enum logic [1:0] {
      RESP_OKAY   = 2'b00,
      RESP_SLVERR = 2'b10
   } axi_resp_e;

   function automatic logic [DATA_W-1:0] apply_strb(
      input logic [DATA_W-1:0] old_w,
      input logic [DATA_W-1:0] new_w,
      input logic [STRB_W-1:0] strb
   );
      logic [DATA_W-1:0] r;
      r = old_w;
      for (int i = 0; i < STRB_W; i++) begin
         if (strb[i]) begin
            r[8*i +: 8] = new_w[8*i +: 8];
         end
      end
      return r;
   endfunction

endpackage

// File: rtl/axil_wr_join.sv
// Captures AW and W independently, joins them into one commit pulse
// and owns the B channel; at most one write is in flight.
module axil_wr_join
   import axil_pkg::*;
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic [31:0]       awaddr,
   input  logic              awvalid,
   output logic              awready,
   input  logic [DATA_W-1:0] wdata,
   input  logic [STRB_W-1:0] wstrb,
   input  logic              wvalid,
   output logic              wready,
   output logic [1:0]        bresp,
   output logic              bvalid,
   input  logic              bready,
   input  logic              wr_err,
   output logic              commit,
   output logic [31:0]       wr_addr,
   output logic [DATA_W-1:0] wr_data,
   output logic [STRB_W-1:0] wr_strb
);

   logic              rdy_q, rdy_d;
   logic              aw_q, aw_d;
   logic              w_q, w_d;
   logic              bvalid_q, bvalid_d;
   logic [1:0]        bresp_q, bresp_d;
   logic [31:0]       addr_q, addr_d;
   logic [DATA_W-1:0] data_q, data_d;
   logic [STRB_W-1:0] strb_q, strb_d;
   logic              aw_hs, w_hs;

   // rdy_q keeps both readies low while in reset and lifts them
   // on the first edge afterwards.
   assign awready = rdy_q & ~aw_q & ~bvalid_q;
   assign wready  = rdy_q & ~w_q & ~bvalid_q;
   assign aw_hs   = awvalid & awready;
   assign w_hs    = wvalid & wready;
   assign commit  = aw_q & w_q & ~bvalid_q;

   always_comb begin
      rdy_d    = 1'b1;
      aw_d     = aw_q;
      w_d      = w_q;
      bvalid_d = bvalid_q;
      bresp_d  = bresp_q;
      addr_d   = addr_q;
      data_d   = data_q;
      strb_d   = strb_q;
      if (aw_hs) begin
         aw_d   = 1'b1;
         addr_d = awaddr;
      end
      if (w_hs) begin
         w_d    = 1'b1;
         data_d = wdata;
         strb_d = wstrb;
      end
      if (commit) begin
         bvalid_d = 1'b1;
         bresp_d  = wr_err ? RESP_SLVERR : RESP_OKAY;
      end
      if (bvalid_q && bready) begin
         aw_d     = 1'b0;
         w_d      = 1'b0;
         bvalid_d = 1'b0;
         bresp_d  = RESP_OKAY;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rdy_q    <= 1'b0;
         aw_q     <= 1'b0;
         w_q      <= 1'b0;
         bvalid_q <= 1'b0;
         bresp_q  <= RESP_OKAY;
         addr_q   <= '0;
         data_q   <= '0;
         strb_q   <= '0;
      end else begin
         rdy_q    <= rdy_d;
         aw_q     <= aw_d;
         w_q      <= w_d;
         bvalid_q <= bvalid_d;
         bresp_q  <= bresp_d;
         addr_q   <= addr_d;
         data_q   <= data_d;
         strb_q   <= strb_d;
      end
   end

   assign bvalid  = bvalid_q;
   assign bresp   = bresp_q;
   assign wr_addr = addr_q;
   assign wr_data = data_q;
   assign wr_strb = strb_q;

endmodule

// File: rtl/axil_regfile.sv
// AXI4-Lite register file: NCTRL r/w control words then NSTAT status words.
// Optional AXIL_REGFILE_SLVERR_EN: SLVERR on out-of-range and status writes.
module axil_regfile
   import axil_pkg::*;
#(
   parameter int unsigned NCTRL     = 8,
   parameter int unsigned NSTAT     = 4,
   parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [31:0]             s_axi_awaddr,
   input  logic [2:0]              s_axi_awprot,
   input  logic                    s_axi_awvalid,
   output logic                    s_axi_awready,
   input  logic [DATA_W-1:0]       s_axi_wdata,
   input  logic [STRB_W-1:0]       s_axi_wstrb,
   input  logic                    s_axi_wvalid,
   output logic                    s_axi_wready,
   output logic [1:0]              s_axi_bresp,
   output logic                    s_axi_bvalid,
   input  logic                    s_axi_bready,
   input  logic [31:0]             s_axi_araddr,
   input  logic [2:0]              s_axi_arprot,
   input  logic                    s_axi_arvalid,
   output logic                    s_axi_arready,
   output logic [DATA_W-1:0]       s_axi_rdata,
   output logic [1:0]              s_axi_rresp,
   output logic                    s_axi_rvalid,
   input  logic                    s_axi_rready,
   output logic [32*NCTRL-1:0]     ctrl_out,
   input  logic [32*NSTAT-1:0]     stat_in
);

   logic [DATA_W-1:0] ctrl_q [NCTRL];
   logic [DATA_W-1:0] ctrl_d [NCTRL];

   logic              commit;
   logic              wr_err;
   logic [31:0]       wr_addr;
   logic [DATA_W-1:0] wr_data;
   logic [STRB_W-1:0] wr_strb;
   logic [31:0]       wr_off;
   logic [29:0]       wr_idx;
   logic              wr_ctrl;

   axil_wr_join u_wr_join (
      .clk     (clk),
      .rst_n   (rst_n),
      .awaddr  (s_axi_awaddr),
      .awvalid (s_axi_awvalid),
      .awready (s_axi_awready),
      .wdata   (s_axi_wdata),
      .wstrb   (s_axi_wstrb),
      .wvalid  (s_axi_wvalid),
      .wready  (s_axi_wready),
      .bresp   (s_axi_bresp),
      .bvalid  (s_axi_bvalid),
      .bready  (s_axi_bready),
      .wr_err  (wr_err),
      .commit  (commit),
      .wr_addr (wr_addr),
      .wr_data (wr_data),
      .wr_strb (wr_strb)
   );

   assign wr_off = wr_addr - BASE_ADDR;
   assign wr_idx = wr_off[31:2];

   always_comb begin
      wr_ctrl = 1'b0;
      for (int k = 0; k < NCTRL; k++) begin
         ctrl_d[k] = ctrl_q[k];
         if (wr_idx == 30'(k)) begin
            wr_ctrl = 1'b1;
            if (commit) begin
               ctrl_d[k] = apply_strb(ctrl_q[k], wr_data, wr_strb);
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int k = 0; k < NCTRL; k++) begin
            ctrl_q[k] <= '0;
         end
      end else begin
         for (int k = 0; k < NCTRL; k++) begin
            ctrl_q[k] <= ctrl_d[k];
         end
      end
   end

   for (genvar g = 0; g < NCTRL; g++) begin : g_ctrl_out
      assign ctrl_out[32*g +: 32] = ctrl_q[g];
   end

   logic              rdy_q, rdy_d;
   logic              rvalid_q, rvalid_d;
   logic [DATA_W-1:0] rdata_q, rdata_d;
   logic [1:0]        rresp_q, rresp_d;
   logic [31:0]       rd_off;
   logic [29:0]       rd_idx;
   logic [DATA_W-1:0] rd_word;
   logic              rd_hit;
   logic              rd_err;
   logic              ar_hs;

   assign rd_off = s_axi_araddr - BASE_ADDR;
   assign rd_idx = rd_off[31:2];

   // Unmatched indices fall through with rd_word = 0.
   always_comb begin
      rd_word = '0;
      rd_hit  = 1'b0;
      for (int k = 0; k < NCTRL; k++) begin
         if (rd_idx == 30'(k)) begin
            rd_word = ctrl_q[k];
            rd_hit  = 1'b1;
         end
      end
      for (int k = 0; k < NSTAT; k++) begin
         if (rd_idx == 30'(NCTRL + k)) begin
            rd_word = stat_in[32*k +: 32];
            rd_hit  = 1'b1;
         end
      end
   end

`ifdef AXIL_REGFILE_SLVERR_EN
   assign wr_err = ~wr_ctrl;
   assign rd_err = ~rd_hit;
`else
   assign wr_err = 1'b0;
   assign rd_err = 1'b0;
`endif

   assign s_axi_arready = rdy_q & ~rvalid_q;
   assign ar_hs         = s_axi_arvalid & s_axi_arready;

   always_comb begin
      rdy_d    = 1'b1;
      rvalid_d = rvalid_q;
      rdata_d  = rdata_q;
      rresp_d  = rresp_q;
      if (rvalid_q && s_axi_rready) begin
         rvalid_d = 1'b0;
      end
      if (ar_hs) begin
         rvalid_d = 1'b1;
         rdata_d  = rd_word;
         rresp_d  = rd_err ? RESP_SLVERR : RESP_OKAY;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rdy_q    <= 1'b0;
         rvalid_q <= 1'b0;
         rdata_q  <= '0;
         rresp_q  <= RESP_OKAY;
      end else begin
         rdy_q    <= rdy_d;
         rvalid_q <= rvalid_d;
         rdata_q  <= rdata_d;
         rresp_q  <= rresp_d;
      end
   end

   assign s_axi_rvalid = rvalid_q;
   assign s_axi_rdata  = rdata_q;
   assign s_axi_rresp  = rresp_q;

   logic unused_ok;
   assign unused_ok = ^{s_axi_awprot, s_axi_arprot, rd_off[1:0],
                        wr_off[1:0], rd_hit, wr_ctrl};

endmodule

// File: tb/tb_axil_regfile.sv
// Directed bench for axil_regfile with hand-computed expectations.
// Builds with or without AXIL_REGFILE_SLVERR_EN.
module tb_axil_regfile;

   localparam int NC = 8;
   localparam int NS = 4;
   localparam logic [1:0] OKAY = 2'b00;
`ifdef AXIL_REGFILE_SLVERR_EN
   localparam logic [1:0] ERR = 2'b10;
`else
   localparam logic [1:0] ERR = 2'b00;
`endif

   logic            clk = 1'b0;
   logic            rst_n = 1'b0;
   logic [31:0]     awaddr = '0;
   logic [2:0]      awprot = '0;
   logic            awvalid = 1'b0;
   logic            awready;
   logic [31:0]     wdata = '0;
   logic [3:0]      wstrb = '0;
   logic            wvalid = 1'b0;
   logic            wready;
   logic [1:0]      bresp;
   logic            bvalid;
   logic            bready = 1'b0;
   logic [31:0]     araddr = '0;
   logic [2:0]      arprot = '0;
   logic            arvalid = 1'b0;
   logic            arready;
   logic [31:0]     rdata;
   logic [1:0]      rresp;
   logic            rvalid;
   logic            rready = 1'b0;
   logic [32*NC-1:0] ctrl_out;
   logic [32*NS-1:0] stat_in = '0;

   int checks = 0;
   int errors = 0;
   logic [31:0] exp_reg [NC];

   always #5 clk = ~clk;

   axil_regfile dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .s_axi_awaddr  (awaddr),
      .s_axi_awprot  (awprot),
      .s_axi_awvalid (awvalid),
      .s_axi_awready (awready),
      .s_axi_wdata   (wdata),
      .s_axi_wstrb   (wstrb),
      .s_axi_wvalid  (wvalid),
      .s_axi_wready  (wready),
      .s_axi_bresp   (bresp),
      .s_axi_bvalid  (bvalid),
      .s_axi_bready  (bready),
      .s_axi_araddr  (araddr),
      .s_axi_arprot  (arprot),
      .s_axi_arvalid (arvalid),
      .s_axi_arready (arready),
      .s_axi_rdata   (rdata),
      .s_axi_rresp   (rresp),
      .s_axi_rvalid  (rvalid),
      .s_axi_rready  (rready),
      .ctrl_out      (ctrl_out),
      .stat_in       (stat_in)
   );

   task automatic chk(input string tag, input logic [255:0] obs,
                      input logic [255:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic chk_regs(input string tag);
      logic [32*NC-1:0] v;
      for (int k = 0; k < NC; k++) v[32*k +: 32] = exp_reg[k];
      chk(tag, ctrl_out, v);
   endtask

   task automatic wr(input logic [31:0] a, input logic [31:0] d,
                     input logic [3:0] s, input logic [1:0] resp,
                     input string tag);
      @(negedge clk);
      chk({tag, " awready"}, awready, 1'b1);
      chk({tag, " wready"}, wready, 1'b1);
      awaddr = a; wdata = d; wstrb = s;
      awvalid = 1'b1; wvalid = 1'b1;
      @(negedge clk);
      awvalid = 1'b0; wvalid = 1'b0;
      chk({tag, " bvalid early"}, bvalid, 1'b0);
      @(negedge clk);
      chk({tag, " bvalid"}, bvalid, 1'b1);
      chk({tag, " bresp"}, bresp, resp);
      bready = 1'b1;
      @(negedge clk);
      bready = 1'b0;
      chk({tag, " bvalid clr"}, bvalid, 1'b0);
   endtask

   task automatic rd(input logic [31:0] a, input logic [31:0] d,
                     input logic [1:0] resp, input string tag);
      @(negedge clk);
      chk({tag, " arready"}, arready, 1'b1);
      araddr = a; arvalid = 1'b1;
      @(negedge clk);
      arvalid = 1'b0;
      chk({tag, " rvalid"}, rvalid, 1'b1);
      chk({tag, " rdata"}, rdata, d);
      chk({tag, " rresp"}, rresp, resp);
      rready = 1'b1;
      @(negedge clk);
      rready = 1'b0;
      chk({tag, " rvalid clr"}, rvalid, 1'b0);
   endtask

   initial begin
      for (int k = 0; k < NC; k++) exp_reg[k] = '0;
      stat_in = {32'h4444_4444, 32'h3333_3333,
                 32'h2222_2222, 32'hDEAD_BEEF};

      // reset state
      @(negedge clk);
      @(negedge clk);
      chk("rst awready", awready, 1'b0);
      chk("rst wready", wready, 1'b0);
      chk("rst arready", arready, 1'b0);
      chk("rst bvalid", bvalid, 1'b0);
      chk("rst rvalid", rvalid, 1'b0);
      chk("rst rdata", rdata, 32'h0);
      chk_regs("rst ctrl");
      rst_n = 1'b1;
      @(negedge clk);
      chk("idle awready", awready, 1'b1);
      chk("idle wready", wready, 1'b1);
      chk("idle arready", arready, 1'b1);

      // single top-lane write to reg1
      wr(32'h04, 32'hA5A5_A5A5, 4'b1000, OKAY, "wr1");
      exp_reg[1] = 32'hA500_0000;
      chk("reg1 lane3", ctrl_out[63:32], 32'hA500_0000);
      chk_regs("after wr1");

      // W three cycles ahead of AW
      @(negedge clk);
      wdata = 32'h1234_5678; wstrb = 4'hF; wvalid = 1'b1;
      @(negedge clk);
      wvalid = 1'b0;
      chk("wfirst wready", wready, 1'b0);
      chk("wfirst awready", awready, 1'b1);
      @(negedge clk);
      chk("wfirst bvalid", bvalid, 1'b0);
      @(negedge clk);
      chk("wfirst reg0 hold", ctrl_out[31:0], 32'h0);
      awaddr = 32'h00; awvalid = 1'b1;
      @(negedge clk);
      awvalid = 1'b0;
      chk("wfirst join bvalid", bvalid, 1'b0);
      chk("wfirst join reg0", ctrl_out[31:0], 32'h0);
      @(negedge clk);
      chk("wfirst commit bvalid", bvalid, 1'b1);
      chk("wfirst reg0", ctrl_out[31:0], 32'h1234_5678);
      bready = 1'b1;
      @(negedge clk);
      bready = 1'b0;
      exp_reg[0] = 32'h1234_5678;

      // status read with rready stalled
      @(negedge clk);
      araddr = 32'h20; arvalid = 1'b1;
      @(negedge clk);
      arvalid = 1'b0;
      stat_in[31:0] = 32'h0BAD_0BAD;
      chk("stat rvalid", rvalid, 1'b1);
      chk("stat rdata", rdata, 32'hDEAD_BEEF);
      chk("stat rresp", rresp, OKAY);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("stall rdata", rdata, 32'hDEAD_BEEF);
         chk("stall arready", arready, 1'b0);
         chk("stall rvalid", rvalid, 1'b1);
      end
      rready = 1'b1;
      chk("rclr arready", arready, 1'b0);
      @(negedge clk);
      rready = 1'b0;
      chk("rclr rvalid", rvalid, 1'b0);
      chk("rclr arready idle", arready, 1'b1);

      rd(32'h2C, 32'h4444_4444, OKAY, "stat3");
      rd(32'h07, 32'hA500_0000, OKAY, "reg1 lowbits");

      // out-of-range and status-write errors
      rd(32'h100, 32'h0, ERR, "oor rd");
      rd(32'h30, 32'h0, ERR, "oor rd edge");
      wr(32'h20, 32'hFFFF_FFFF, 4'hF, ERR, "stat wr");
      wr(32'h100, 32'hFFFF_FFFF, 4'hF, ERR, "oor wr");
      chk_regs("after err wr");

      // read and write of reg0 landing on the same edge
      @(negedge clk);
      awaddr = 32'h00; wdata = 32'hCAFE_F00D; wstrb = 4'hF;
      awvalid = 1'b1; wvalid = 1'b1;
      @(negedge clk);
      awvalid = 1'b0; wvalid = 1'b0;
      araddr = 32'h00; arvalid = 1'b1;
      @(negedge clk);
      arvalid = 1'b0;
      chk("rw rdata old", rdata, 32'h1234_5678);
      chk("rw bvalid", bvalid, 1'b1);
      chk("rw reg0 new", ctrl_out[31:0], 32'hCAFE_F00D);
      bready = 1'b1; rready = 1'b1;
      @(negedge clk);
      bready = 1'b0; rready = 1'b0;
      exp_reg[0] = 32'hCAFE_F00D;

      // empty and partial strobes
      wr(32'h08, 32'hFFFF_FFFF, 4'b0000, OKAY, "strb0");
      wr(32'h0C, 32'h1122_3344, 4'b0101, OKAY, "strb5");
      exp_reg[3] = 32'h0022_0044;
      chk_regs("after strb");

      // bready stall then back-to-back write
      @(negedge clk);
      awaddr = 32'h10; wdata = 32'h0000_0001; wstrb = 4'hF;
      awvalid = 1'b1; wvalid = 1'b1;
      @(negedge clk);
      awaddr = 32'h14; wdata = 32'h0000_0002;
      @(negedge clk);
      for (int i = 0; i < 4; i++) begin
         chk("bstall bvalid", bvalid, 1'b1);
         chk("bstall awready", awready, 1'b0);
         chk("bstall wready", wready, 1'b0);
         @(negedge clk);
      end
      chk("bstall reg5", ctrl_out[191:160], 32'h0);
      bready = 1'b1;
      @(negedge clk);
      bready = 1'b0;
      chk("b2b awready", awready, 1'b1);
      chk("b2b wready", wready, 1'b1);
      @(negedge clk);
      awvalid = 1'b0; wvalid = 1'b0;
      chk("b2b bvalid early", bvalid, 1'b0);
      @(negedge clk);
      chk("b2b bvalid", bvalid, 1'b1);
      bready = 1'b1;
      @(negedge clk);
      bready = 1'b0;
      exp_reg[4] = 32'h1;
      exp_reg[5] = 32'h2;
      chk_regs("after b2b");

      // reset after AW capture, before W
      @(negedge clk);
      awaddr = 32'h18; awvalid = 1'b1;
      @(negedge clk);
      awvalid = 1'b0;
      chk("abort wready", wready, 1'b1);
      rst_n = 1'b0;
      wdata = 32'h7777_7777; wstrb = 4'hF; wvalid = 1'b1;
      #1;
      for (int k = 0; k < NC; k++) exp_reg[k] = '0;
      chk("arst awready", awready, 1'b0);
      chk("arst wready", wready, 1'b0);
      chk("arst arready", arready, 1'b0);
      chk("arst bvalid", bvalid, 1'b0);
      chk("arst rvalid", rvalid, 1'b0);
      chk("arst bresp", bresp, 2'b00);
      chk("arst rresp", rresp, 2'b00);
      chk("arst rdata", rdata, 32'h0);
      chk_regs("arst ctrl");
      @(negedge clk);
      @(negedge clk);
      chk("arst hold bvalid", bvalid, 1'b0);
      wvalid = 1'b0;
      rst_n = 1'b1;
      @(negedge clk);
      chk("post rst awready", awready, 1'b1);
      chk("post rst wready", wready, 1'b1);
      chk("post rst bvalid", bvalid, 1'b0);
      rd(32'h00, 32'h0, OKAY, "post rst reg0");
      rd(32'h18, 32'h0, OKAY, "post rst reg6");
      chk_regs("post rst ctrl");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
